// File: rtl/codificador_pkg.sv
// Shared constants for the BCD-to-7-segment encoder: segment indices and the glyph table.
// Codes 10-15 show hex glyphs when CODIFICADOR_HEX_EN is defined; otherwise they are dark.
package codificador_pkg;

    localparam int unsigned SEG_A = 32'd6;
    localparam int unsigned SEG_B = 32'd5;
    localparam int unsigned SEG_C = 32'd4;
    localparam int unsigned SEG_D = 32'd3;
    localparam int unsigned SEG_E = 32'd2;
    localparam int unsigned SEG_F = 32'd1;
    localparam int unsigned SEG_G = 32'd0;

    localparam logic [6:0] SEG_ALL_ON  = 7'b1111111;
    localparam logic [6:0] SEG_ALL_OFF = 7'b0000000;

    // Glyphs are stored a..g from MSB to LSB, active-high.
    localparam logic [6:0] GLYPH_TABLE [0:15] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011,
`ifdef CODIFICADOR_HEX_EN
        7'b1110111, 7'b0011111, 7'b1001110,
        7'b0111101, 7'b1001111, 7'b1000111
`else
        7'b0000000, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000
`endif
    };

    localparam logic [3:0] LAST_DEC_CODE = 4'd9;

endpackage

// File: rtl/codificador_seg_lut.sv
// Combinational code-to-glyph lookup returning {valid, seg[6:0]}.
// With CODIFICADOR_HEX_EN defined every code is valid.
module codificador_seg_lut
    import codificador_pkg::*;
(
    input  logic [3:0] code,
    output logic       valid,
    output logic [6:0] seg
);

    // Table lookup and validity of the digit code.
    always_comb begin
        seg = GLYPH_TABLE[code];
`ifdef CODIFICADOR_HEX_EN
        valid = 1'b1;
`else
        valid = (code <= LAST_DEC_CODE);
`endif
    end

endmodule

// File: rtl/codificador_bcd_seg.sv
// Registered BCD-to-7-segment encoder with lamp test, blanking and ripple blanking.
// Optional hex glyphs for codes 10-15 via CODIFICADOR_HEX_EN.
module codificador_bcd_seg
    import codificador_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] BCD,
    input  logic       lamp_test,
    input  logic       blank,
    input  logic       rbi,
    output logic [6:0] S,
    output logic       rbo,
    output logic       err
);

    logic       lut_valid_s;
    logic [6:0] lut_seg_s;
    logic [6:0] seg_next_s;
    logic       rbo_next_s;
    logic       zero_s;
    logic [6:0] seg_r;
    logic       rbo_r;
    logic       err_r;

    codificador_seg_lut u_lut (
        .code  (BCD),
        .valid (lut_valid_s),
        .seg   (lut_seg_s)
    );

    assign zero_s = (BCD == 4'd0);

    // Priority mux: lamp test over blank over ripple blank over table decode.
    always_comb begin
        seg_next_s = SEG_ALL_OFF;
        rbo_next_s = 1'b0;
        if (lamp_test) begin
            seg_next_s = SEG_ALL_ON;
        end else if (blank) begin
            seg_next_s = SEG_ALL_OFF;
        end else if (rbi && zero_s) begin
            seg_next_s = SEG_ALL_OFF;
            rbo_next_s = 1'b1;
        end else begin
            seg_next_s = lut_seg_s;
        end
    end

    // Output registers; err tracks code validity independently of the overrides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= SEG_ALL_OFF;
            rbo_r <= 1'b0;
            err_r <= 1'b0;
        end else if (en) begin
            seg_r <= seg_next_s;
            rbo_r <= rbo_next_s;
            err_r <= ~lut_valid_s;
        end else begin
            seg_r <= seg_r;
            rbo_r <= rbo_r;
            err_r <= err_r;
        end
    end

    // Polarity is applied after the register so reset shows dark segments either way.
    assign S   = seg_r ^ {7{SEG_ACTIVE_LOW}};
    assign rbo = rbo_r;
    assign err = err_r;

endmodule

// File: tb/tb_codificador_bcd_seg.sv
// Directed self-checking bench for codificador_bcd_seg (active-high and active-low instances).
// Expected values follow CODIFICADOR_HEX_EN when it is defined.
module tb_codificador_bcd_seg;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] BCD;
    logic       lamp_test;
    logic       blank;
    logic       rbi;
    logic [6:0] s_hi;
    logic       rbo_hi;
    logic       err_hi;
    logic [6:0] s_lo;
    logic       rbo_lo;
    logic       err_lo;

    int vectors;
    int miscompares;

    logic [6:0] exp_tab [0:15];
    logic       exp_err_tab [0:15];

    codificador_bcd_seg #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .BCD(BCD), .lamp_test(lamp_test),
        .blank(blank), .rbi(rbi), .S(s_hi), .rbo(rbo_hi), .err(err_hi)
    );

    codificador_bcd_seg #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .BCD(BCD), .lamp_test(lamp_test),
        .blank(blank), .rbi(rbi), .S(s_lo), .rbo(rbo_lo), .err(err_lo)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] exp_s,
                         input logic exp_rbo, input logic exp_err);
        logic [8:0] obs_hi;
        logic [8:0] obs_lo;
        logic [8:0] exp_hi;
        logic [8:0] exp_lo;
        obs_hi = {s_hi, rbo_hi, err_hi};
        obs_lo = {s_lo, rbo_lo, err_lo};
        exp_hi = {exp_s, exp_rbo, exp_err};
        exp_lo = {~exp_s, exp_rbo, exp_err};
        vectors++;
        assert (obs_hi === exp_hi) else begin
            miscompares++;
            $error("FAIL %s active-high {S,rbo,err} observed=%b expected=%b", tag, obs_hi, exp_hi);
        end
        vectors++;
        assert (obs_lo === exp_lo) else begin
            miscompares++;
            $error("FAIL %s active-low {S,rbo,err} observed=%b expected=%b", tag, obs_lo, exp_lo);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_tab = '{
            7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011,
`ifdef CODIFICADOR_HEX_EN
            7'b1110111, 7'b0011111, 7'b1001110,
            7'b0111101, 7'b1001111, 7'b1000111
`else
            7'b0000000, 7'b0000000, 7'b0000000,
            7'b0000000, 7'b0000000, 7'b0000000
`endif
        };
        for (int i = 0; i < 16; i++) begin
`ifdef CODIFICADOR_HEX_EN
            exp_err_tab[i] = 1'b0;
`else
            exp_err_tab[i] = (i > 9) ? 1'b1 : 1'b0;
`endif
        end

        rst       = 1'b1;
        en        = 1'b1;
        BCD       = 4'd8;
        lamp_test = 1'b0;
        blank     = 1'b0;
        rbi       = 1'b0;

        #15;
        check("reset_initial", 7'b0000000, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            BCD = 4'(i);
            step();
            check($sformatf("sweep_%0d", i), exp_tab[i], 1'b0, exp_err_tab[i]);
        end

        BCD = 4'd8;
        step();
        check("show_8", 7'b1111111, 1'b0, 1'b0);
        #4 rst = 1'b1;
        #1;
        check("async_reset", 7'b0000000, 1'b0, 1'b0);
        #1 rst = 1'b0;

        BCD       = 4'd3;
        lamp_test = 1'b1;
        blank     = 1'b1;
        step();
        check("lamp_and_blank", 7'b1111111, 1'b0, 1'b0);
        lamp_test = 1'b0;
        step();
        check("blank_only", 7'b0000000, 1'b0, 1'b0);
        blank = 1'b0;
        step();
        check("decode_3", 7'b1111001, 1'b0, 1'b0);

        BCD       = 4'd12;
        lamp_test = 1'b1;
        step();
        check("lamp_invalid_err", 7'b1111111, 1'b0, exp_err_tab[12]);
        lamp_test = 1'b0;

        rbi = 1'b1;
        BCD = 4'd0;
        step();
        check("ripple_zero", 7'b0000000, 1'b1, 1'b0);
        BCD = 4'd5;
        step();
        check("ripple_nonzero", 7'b1011011, 1'b0, 1'b0);
        BCD   = 4'd0;
        blank = 1'b1;
        step();
        check("ripple_blanked", 7'b0000000, 1'b0, 1'b0);
        blank     = 1'b0;
        lamp_test = 1'b1;
        step();
        check("ripple_lamp", 7'b1111111, 1'b0, 1'b0);
        lamp_test = 1'b0;
        rbi       = 1'b0;
        step();
        check("zero_no_rbi", 7'b1111110, 1'b0, 1'b0);

        BCD = 4'd7;
        step();
        check("latch_7", 7'b1110000, 1'b0, 1'b0);
        en  = 1'b0;
        BCD = 4'd2;
        step();
        check("hold_1", 7'b1110000, 1'b0, 1'b0);
        BCD = 4'd11;
        step();
        check("hold_invalid", 7'b1110000, 1'b0, 1'b0);
        BCD = 4'd2;
        en  = 1'b1;
        step();
        check("resume_2", 7'b1101101, 1'b0, 1'b0);

        BCD = 4'd1;
        step();
        check("active_low_1", 7'b0110000, 1'b0, 1'b0);
        vectors++;
        assert (s_lo === 7'b1001111) else begin
            miscompares++;
            $error("FAIL active_low_pins observed=%b expected=%b", s_lo, 7'b1001111);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/codificador_bcd_seg.md
Name: codificador_bcd_seg

Overview:
- Registered BCD-to-7-segment encoder.
- Converts a 4-bit BCD digit into active-high segment drive S[6:0].
- Supports lamp test, forced blanking and ripple (leading-zero) blanking for cascading multi-digit displays.
- Sits between digit-formatting logic and display pin drivers; one instance per digit.

Parameters:
- SEG_ACTIVE_LOW, 0, when 1 the final S output is inverted for common-anode displays; all internal logic stays active-high.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- en  in  1  update enable; when 0 all registered outputs hold
- BCD  in  4  digit code; 0-9 valid, 10-15 invalid
- lamp_test  in  1  force all segments on
- blank  in  1  force all segments off
- rbi  in  1  ripple-blank in; suppress a zero digit
- S  out  7  segment drive, S[6]=a, S[5]=b, S[4]=c, S[3]=d, S[2]=e, S[1]=f, S[0]=g
- rbo  out  1  ripple-blank out to the next lower digit
- err  out  1  registered flag; current digit code is invalid

Behaviour:
- Reset:
  - rst is asynchronous and active-high.
  - While rst=1: S = 7'b0000000 (inverted when SEG_ACTIVE_LOW=1), rbo=0, err=0.
  - Outputs may update on the first rising edge after rst deasserts.
- Latency: one clock. Inputs sampled at a rising edge with en=1 appear on S/rbo/err after that edge. With en=0 the registers hold.
- Segment table (a..g, active-high):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Invalid codes 10-15: S=0000000 and err=1. err=0 for any valid code.
- Priority, highest first:
  1. rst.
  2. lamp_test: S=1111111.
  3. blank: S=0000000.
  4. Ripple blank: rbi=1 and BCD=0 gives S=0000000.
  5. Table decode.
- err reflects BCD validity only, regardless of lamp_test or blank.
- rbo is 1 when rbi=1, BCD=0, lamp_test=0 and blank=0; otherwise 0. It is registered together with S.
- rbo of the more significant digit is intended to drive rbi of the next lower digit. The least significant digit instance ties rbi=0 so a lone 0 is always shown.
- SEG_ACTIVE_LOW: inversion is applied after the output register. The reset value therefore becomes 7'b1111111 (all segments dark).
- Simultaneous lamp_test and blank: lamp_test wins.
- Changes to BCD when en=0 are ignored until en returns to 1.

Optional Feature:
- Macro CODIFICADOR_HEX_EN.
- When defined, codes 10-15 display hex glyphs and err is tied to 0:
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- When undefined, codes 10-15 blank the digit and assert err as specified above.
- Ripple blanking applies only to code 0 in both builds.

Decomposition:
- Package codificador_pkg holds:
  - segment index constants SEG_A..SEG_G
  - the 16-entry glyph constant array (entries 10-15 selected by the macro)
  - constants SEG_ALL_ON and SEG_ALL_OFF
- One combinational sub-module, codificador_seg_lut, maps 4-bit code to {valid, seg[6:0]}.
- The top level adds priority muxing, ripple logic, registers and polarity inversion.

Test Plan:
- Reset: assert rst mid-operation with S showing 8 -> S=0000000, rbo=0, err=0 immediately, without waiting for a clock edge.
- Sweep BCD 0..15, en=1, other controls 0, 20 ns apart -> each edge after sampling gives the table pattern. Codes 10-15 give S=0000000, err=1 (without the macro) or the hex glyphs with err=0 (with CODIFICADOR_HEX_EN).
- lamp_test=1 and blank=1 together with BCD=3 -> S=1111111, err=0. Drop lamp_test -> S=0000000. Drop blank -> S=1111001.
- Ripple blanking:
  - rbi=1, BCD=0 -> S=0000000, rbo=1.
  - rbi=1, BCD=5 -> S=1011011, rbo=0.
  - rbi=0, BCD=0 -> S=1111110, rbo=0.
- Enable hold: BCD=7 latched (S=1110000), then en=0 and BCD=2 -> S stays 1110000. en=1 -> S=1101101 one edge later.
- SEG_ACTIVE_LOW=1, BCD=1 -> S=1001111. During reset S=1111111.
